mips_lsu: RTL and testbench

Load/store unit that initiates accesses on the CPU data-memory bus. It drives data_address/data_read/data_write/data_writedata toward a word-wide data RAM, which reads combinationally and writes on the clock edge. It accepts one LB/LBU/LH/LHU/LW/SB/SH/SW request at a time over a valid/ready handshake from the pipeline. It returns a one-cycle response and performs byte-lane selection, sign/zero extension, read-modify-write for sub-word stores, and byte reversal between CPU register order and RAM word order.

---
 rtl/mips_lsu.sv | 146 ++++++++++++++
 tb/tb_mips_lsu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_lsu.sv
// Load/store unit: one request at a time, byte-lane select with sign/zero extension,
// read-modify-write for SB/SH, and CPU big-endian <-> RAM byte-reversed word order.
module mips_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [31:0] addr_reg;
  logic [15:0] wdata_reg;
  logic [31:0] wword_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic        accept;
  logic        req_half;
  logic        req_word;
  logic        misalign;
  logic        op_is_store;
  logic [31:0] rd_swapped;
  logic [31:0] wr_swapped;
  logic [31:0] sb_merged;
  logic [31:0] sh_merged;
  logic [31:0] load_result;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign req_ready = (state_reg == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  assign req_half    = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
  assign req_word    = (req_op == OP_LW) || (req_op == OP_SW);
  assign misalign    = (req_half && req_addr[0]) || (req_word && (req_addr[1:0] != 2'b00));
  assign op_is_store = op_reg[2] && (op_reg != OP_LW);

  // Byte reversal both ways, plus the per-lane merge used by SB/SH.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam int HI = (gi % 2 == 0) ? 15 : 7;
      assign rd_swapped[8*gi +: 8] = data_readdata[8*(3-gi) +: 8];
      assign wr_swapped[8*gi +: 8] = req_wdata[8*(3-gi) +: 8];
      assign sb_merged[8*gi +: 8]  = (addr_reg[1:0] == 2'(gi)) ? wdata_reg[7:0]
                                                                : data_readdata[8*gi +: 8];
      assign sh_merged[8*gi +: 8]  = (addr_reg[1] == 1'(gi / 2)) ? wdata_reg[HI -: 8]
                                                                  : data_readdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = data_readdata[{addr_reg[1:0], 3'b000} +: 8];
  assign half_sel = {data_readdata[{addr_reg[1], 4'b0000} +: 8],
                     data_readdata[{addr_reg[1], 4'b1000} +: 8]};

  always_comb begin
    load_result = rd_swapped;
    case (op_reg)
      OP_LB:   load_result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_result = {24'h0, byte_sel};
      OP_LH:   load_result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_result = {16'h0, half_sel};
      default: load_result = rd_swapped;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (misalign)             state_next = RESP;
          else if (req_op == OP_SW) state_next = WRITE;
          else                      state_next = READ;
        end
      end
      READ:    state_next = op_is_store ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg    <= 3'b000;
      addr_reg  <= 32'h0;
      wdata_reg <= 16'h0;
      wword_reg <= 32'h0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        op_reg    <= req_op;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata[15:0];
        err_reg   <= misalign;
        // SW skips READ, so its RAM-order word is formed at accept time.
        wword_reg <= wr_swapped;
        if (misalign) rdata_reg <= 32'h0;
      end
      if (state_reg == READ) begin
        if (op_is_store) wword_reg <= (op_reg == OP_SB) ? sb_merged : sh_merged;
        else             rdata_reg <= load_result;
      end
      if (state_reg == WRITE) rdata_reg <= 32'h0;
    end
  end

  assign resp_valid     = (state_reg == RESP);
  assign resp_err       = resp_valid && err_reg;
  assign resp_rdata     = rdata_reg;
  assign data_read      = (state_reg == READ);
  assign data_write     = (state_reg == WRITE);
  assign data_address   = (data_read || data_write) ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign data_writedata = data_write ? wword_reg : 32'h0;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu with a small word RAM (combinational read, posedge write).
module tb_mips_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  int check_count = 0;
  int pass_count  = 0;

  int          rd_cnt, wr_cnt, resp_cnt;
  logic [31:0] last_rd_addr, last_wr_addr, last_wdata;

  logic [31:0] ram [0:15];

  always #5 clk = ~clk;

  mips_lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  assign data_readdata = ram[data_address[5:2]];

  always @(posedge clk) begin
    if (data_write) ram[data_address[5:2]] <= data_writedata;
  end

  always @(negedge clk) begin
    if (data_read)  begin rd_cnt++; last_rd_addr = data_address; end
    if (data_write) begin wr_cnt++; last_wr_addr = data_address; last_wdata = data_writedata; end
    if (resp_valid) resp_cnt++;
  end

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) lat = 99;
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_count++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready got %b expected 0", req_ready); else pass_count++;
    check_count++;
    if ({resp_valid, resp_err, data_read, data_write} !== 4'b0)
      $display("FAIL reset_ctrl got %b expected 0000", {resp_valid, resp_err, data_read, data_write});
    else pass_count++;
    check_count++;
    if ({data_address, data_writedata, resp_rdata} !== 96'h0)
      $display("FAIL reset_data got %h/%h/%h expected 0", data_address, data_writedata, resp_rdata);
    else pass_count++;
    reset = 1'b0; #1;
    check_count++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready got %b expected 1", req_ready); else pass_count++;
  endtask

  task automatic test_loads();
    logic [2:0]  ops   [6] = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b010, 3'b011};
    logic [31:0] addrs [6] = '{32'h0, 32'h4, 32'h4, 32'h1, 32'h4, 32'h6};
    logic [31:0] exps  [6] = '{32'h12345678, 32'hFFFFFFEE, 32'h000000EE,
                               32'h00000034, 32'hFFFFEEEE, 32'h000068AC};
    int lat; logic [31:0] rd; logic err;
    for (int i = 0; i < 6; i++) begin
      do_req(ops[i], addrs[i], 32'h0, lat, rd, err);
      $display("load op=%0d addr=%h rdata=%h err=%b lat=%0d", ops[i], addrs[i], rd, err, lat);
      check_count++;
      if (rd !== exps[i]) $display("FAIL load%0d_rdata got %h expected %h", i, rd, exps[i]); else pass_count++;
      check_count++;
      if (lat !== 2 || err !== 1'b0) $display("FAIL load%0d_lat_err got %0d/%b expected 2/0", i, lat, err); else pass_count++;
      check_count++;
      if (rd_cnt !== 1 || wr_cnt !== 0 || last_rd_addr !== {addrs[i][31:2], 2'b00})
        $display("FAIL load%0d_bus got rd=%0d wr=%0d addr=%h expected 1/0/%h", i, rd_cnt, wr_cnt,
                 last_rd_addr, {addrs[i][31:2], 2'b00});
      else pass_count++;
    end
  endtask

  task automatic test_sub_stores();
    int lat; logic [31:0] rd; logic err;
    do_req(3'b101, 32'h2, 32'hFFFFFFAB, lat, rd, err);
    $display("SB addr=00000002 wdata=ffffffab lat=%0d writedata=%h", lat, last_wdata);
    check_count++;
    if (lat !== 3 || rd_cnt !== 1 || wr_cnt !== 1)
      $display("FAIL sb_timing got lat=%0d rd=%0d wr=%0d expected 3/1/1", lat, rd_cnt, wr_cnt);
    else pass_count++;
    check_count++;
    if (last_wdata !== 32'h78AB3412) $display("FAIL sb_writedata got %h expected 78ab3412", last_wdata); else pass_count++;
    check_count++;
    if (rd !== 32'h0 || err !== 1'b0) $display("FAIL sb_resp got %h/%b expected 0/0", rd, err); else pass_count++;
    do_req(3'b100, 32'h0, 32'h0, lat, rd, err);
    $display("LW addr=00000000 rdata=%h", rd);
    check_count++;
    if (rd !== 32'h1234AB78) $display("FAIL sb_readback got %h expected 1234ab78", rd); else pass_count++;

    do_req(3'b110, 32'h6, 32'h0000BEEF, lat, rd, err);
    $display("SH addr=00000006 wdata=0000beef lat=%0d writedata=%h", lat, last_wdata);
    check_count++;
    if (lat !== 3 || last_wr_addr !== 32'h4 || last_wdata !== 32'hEFBEEEEE)
      $display("FAIL sh_write got lat=%0d addr=%h data=%h expected 3/00000004/efbeeeee", lat, last_wr_addr, last_wdata);
    else pass_count++;
    do_req(3'b100, 32'h4, 32'h0, lat, rd, err);
    $display("LW addr=00000004 rdata=%h", rd);
    check_count++;
    if (rd !== 32'hEEEEBEEF) $display("FAIL sh_readback got %h expected eeeebeef", rd); else pass_count++;
  endtask

  task automatic test_sw();
    int lat; logic [31:0] rd; logic err;
    do_req(3'b111, 32'h8, 32'hDEADBEEF, lat, rd, err);
    $display("SW addr=00000008 wdata=deadbeef lat=%0d writedata=%h", lat, last_wdata);
    check_count++;
    if (lat !== 2 || rd_cnt !== 0 || wr_cnt !== 1)
      $display("FAIL sw_timing got lat=%0d rd=%0d wr=%0d expected 2/0/1", lat, rd_cnt, wr_cnt);
    else pass_count++;
    check_count++;
    if (last_wdata !== 32'hEFBEADDE || last_wr_addr !== 32'h8)
      $display("FAIL sw_write got %h@%h expected efbeadde@00000008", last_wdata, last_wr_addr);
    else pass_count++;
    do_req(3'b100, 32'h8, 32'h0, lat, rd, err);
    $display("LW addr=00000008 rdata=%h", rd);
    check_count++;
    if (rd !== 32'hDEADBEEF) $display("FAIL sw_readback got %h expected deadbeef", rd); else pass_count++;
  endtask

  task automatic test_misaligned();
    logic [2:0]  ops   [3] = '{3'b100, 3'b110, 3'b011};
    logic [31:0] addrs [3] = '{32'h2, 32'h3, 32'h5};
    int lat; logic [31:0] rd; logic err;
    for (int i = 0; i < 3; i++) begin
      do_req(ops[i], addrs[i], 32'h12345678, lat, rd, err);
      $display("misaligned op=%0d addr=%h err=%b lat=%0d", ops[i], addrs[i], err, lat);
      check_count++;
      if (err !== 1'b1 || lat !== 1) $display("FAIL mis%0d_err_lat got %b/%0d expected 1/1", i, err, lat); else pass_count++;
      check_count++;
      if (rd_cnt !== 0 || wr_cnt !== 0) $display("FAIL mis%0d_bus got rd=%0d wr=%0d expected 0/0", i, rd_cnt, wr_cnt); else pass_count++;
    end
  endtask

  task automatic test_reset_abort();
    int n; int lat; logic [31:0] rd; logic err;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
    req_op = 3'b110; req_addr = 32'h4; req_wdata = 32'h00001111; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_count++;
    if (data_read !== 1'b1) $display("FAIL abort_in_read got %b expected 1", data_read); else pass_count++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; #1;
    check_count++;
    if (req_ready !== 1'b1) $display("FAIL abort_ready got %b expected 1", req_ready); else pass_count++;
    repeat (3) @(negedge clk);
    $display("abort SH addr=00000004 writes=%0d resps=%0d ram1=%h", wr_cnt, resp_cnt, ram[1]);
    check_count++;
    if (wr_cnt !== 0 || resp_cnt !== 0) $display("FAIL abort_no_write_resp got %0d/%0d expected 0/0", wr_cnt, resp_cnt); else pass_count++;
    check_count++;
    if (ram[1] !== 32'hEFBEEEEE) $display("FAIL abort_ram got %h expected efbeeeee", ram[1]); else pass_count++;
    do_req(3'b100, 32'h4, 32'h0, lat, rd, err);
    check_count++;
    if (rd !== 32'hEEEEBEEF) $display("FAIL abort_readback got %h expected eeeebeef", rd); else pass_count++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic err;
    do_req(3'b000, 32'h3, 32'h0, lat, rd, err);
    $display("LB addr=00000003 rdata=%h", rd);
    check_count++;
    if (rd !== 32'h00000078) $display("FAIL b2b_lb got %h expected 00000078", rd); else pass_count++;
    do_req(3'b011, 32'h0, 32'h0, lat, rd, err);
    $display("LHU addr=00000000 rdata=%h", rd);
    check_count++;
    if (rd !== 32'h00001234) $display("FAIL b2b_lhu got %h expected 00001234", rd); else pass_count++;
    do_req(3'b100, 32'hFFFFFFFC, 32'h0, lat, rd, err);
    $display("LW addr=fffffffc rdata=%h bus_addr=%h", rd, last_rd_addr);
    check_count++;
    if (rd !== 32'h11223344 || last_rd_addr !== 32'hFFFFFFFC)
      $display("FAIL wrap_lw got %h@%h expected 11223344@fffffffc", rd, last_rd_addr);
    else pass_count++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    ram[0]  = 32'h78563412;
    ram[1]  = 32'hAC68EEEE;
    ram[15] = 32'h44332211;
    rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
    last_rd_addr = 32'h0; last_wr_addr = 32'h0; last_wdata = 32'h0;
    test_reset();
    test_loads();
    test_sub_stores();
    test_sw();
    test_misaligned();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end
endmodule
